int_linear_tm: RTL and testbench

- Time-multiplexed integer linear layer with runtime-loadable weights and bias.
- One instance implements one backbone or output layer of the DPD network: y = act(requant(W·x + b)).
- Replaces compile-time weight constants with a write port, so coefficients can be re-trained without resynthesis.
- Throughput is traded against area through PARALLEL_INPUTS.

---
 rtl/int_linear_tm.sv | 204 ++++++++++++++++++++
 tb/tb_int_linear_tm.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_linear_tm.sv
// Time-multiplexed integer linear layer y = act(requant(W*x + b)) with a
// runtime coefficient write port; PARALLEL_INPUTS products are summed per cycle.
//
// state | meaning
// IDLE  | ready for a vector, coefficient writes accepted
// MAC   | accumulating chunk k of neuron j, bias and requantise on the last chunk
// DONE  | result held on out_data until out_ready
module int_linear_tm #(
    parameter int IN_SIZE         = 14,
    parameter int OUT_SIZE        = 12,
    parameter int PARALLEL_INPUTS = 3,
    parameter int A_WIDTH         = 14,
    parameter int W_WIDTH         = 14,
    parameter int OUT_WIDTH       = 14,
    parameter int ACC_WIDTH       = 40,
    parameter int BIAS_SHIFT      = 13,
    parameter int OUT_SHIFT       = 13,
    parameter     ACTIVATION      = "RELU"
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [IN_SIZE*A_WIDTH-1:0]                     in_data,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [OUT_SIZE*OUT_WIDTH-1:0]                  out_data,
    input  logic                                           wr_en,
    input  logic [$clog2(IN_SIZE*OUT_SIZE+OUT_SIZE)-1:0]   wr_addr,
    input  logic [W_WIDTH-1:0]                             wr_data,
    output logic                                           wr_err,
    output logic                                           busy
);
    localparam int NCOEF  = IN_SIZE*OUT_SIZE + OUT_SIZE;
    localparam int AW     = $clog2(NCOEF);
    localparam int P      = PARALLEL_INPUTS;
    localparam int NCHUNK = (IN_SIZE + P - 1) / P;
    localparam int IW     = (IN_SIZE  > 1) ? $clog2(IN_SIZE)  : 1;
    localparam int JW     = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam int KW     = (NCHUNK   > 1) ? $clog2(NCHUNK)   : 1;
    localparam int PW     = A_WIDTH + W_WIDTH;
    localparam bit RELU_EN = (ACTIVATION == "RELU");

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic signed [ACC_WIDTH-1:0] ROUND   = ACC_WIDTH'(1) << (OUT_SHIFT - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    if (ACC_WIDTH < A_WIDTH + W_WIDTH + $clog2(IN_SIZE) + 1) begin : g_acc_check
        $error("int_linear_tm: ACC_WIDTH too small for the dot product");
    end

    logic [1:0]                  state_q, state_d;
    logic [JW-1:0]               j_q, j_d;
    logic [KW-1:0]               k_q, k_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic signed [A_WIDTH-1:0]   x_q [IN_SIZE];
    logic signed [A_WIDTH-1:0]   x_d [IN_SIZE];
    logic signed [W_WIDTH-1:0]   coef_q [NCOEF];
    logic signed [W_WIDTH-1:0]   coef_d [NCOEF];
    logic signed [OUT_WIDTH-1:0] y_q [OUT_SIZE];
    logic signed [OUT_WIDTH-1:0] y_d [OUT_SIZE];
    logic                        in_ready_q, in_ready_d;
    logic                        out_valid_q, out_valid_d;
    logic                        busy_q, busy_d;
    logic                        wr_err_q, wr_err_d;

    logic                        wr_ok;
    logic [IW-1:0]               xi;
    logic [AW-1:0]               wi;
    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH-1:0] chunk_sum;
    logic signed [ACC_WIDTH-1:0] bias_sh;
    logic signed [ACC_WIDTH-1:0] r_sum;
    logic signed [ACC_WIDTH-1:0] r_rnd;
    logic signed [OUT_WIDTH-1:0] q_val;

    // Products of the current chunk; lanes past the last input contribute nothing.
    always_comb begin
        chunk_sum = '0;
        xi        = '0;
        wi        = '0;
        prod      = '0;
        for (int p = 0; p < P; p++) begin
            if (int'(k_q) * P + p < IN_SIZE) begin
                xi        = IW'(int'(k_q) * P + p);
                wi        = AW'(int'(j_q) * IN_SIZE + int'(k_q) * P + p);
                prod      = PW'(x_q[xi]) * PW'(coef_q[wi]);
                chunk_sum = chunk_sum + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
            end
        end
        bias_sh = ACC_WIDTH'(coef_q[AW'(IN_SIZE*OUT_SIZE + int'(j_q))]) <<< BIAS_SHIFT;
        r_sum   = acc_q + chunk_sum + bias_sh;
        r_rnd   = (r_sum + ROUND) >>> OUT_SHIFT;
        if (r_rnd > SAT_MAX) begin
            q_val = SAT_MAX[OUT_WIDTH-1:0];
        end else if (r_rnd < SAT_MIN) begin
            q_val = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            q_val = r_rnd[OUT_WIDTH-1:0];
        end
        if (RELU_EN && q_val[OUT_WIDTH-1]) begin
            q_val = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        x_d     = x_q;
        y_d     = y_q;
        coef_d  = coef_q;

        wr_ok    = wr_en && (state_q == S_IDLE) && ({1'b0, wr_addr} < (AW+1)'(NCOEF));
        wr_err_d = wr_en && !wr_ok;
        if (wr_ok) begin
            coef_d[wr_addr] = wr_data;
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    for (int i = 0; i < IN_SIZE; i++) begin
                        x_d[i] = in_data[i*A_WIDTH +: A_WIDTH];
                    end
                    acc_d   = '0;
                    j_d     = '0;
                    k_d     = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                if (k_q == KW'(NCHUNK - 1)) begin
                    y_d[j_q] = q_val;
                    acc_d    = '0;
                    k_d      = '0;
                    if (j_q == JW'(OUT_SIZE - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    acc_d = acc_q + chunk_sum;
                    k_d   = k_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d  = (state_d == S_IDLE);
        busy_d      = (state_d == S_MAC);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            j_q         <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            wr_err_q    <= 1'b0;
            for (int i = 0; i < IN_SIZE; i++)  x_q[i]    <= '0;
            for (int i = 0; i < NCOEF; i++)    coef_q[i] <= '0;
            for (int i = 0; i < OUT_SIZE; i++) y_q[i]    <= '0;
        end else begin
            state_q     <= state_d;
            j_q         <= j_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            wr_err_q    <= wr_err_d;
            x_q         <= x_d;
            coef_q      <= coef_d;
            y_q         <= y_d;
        end
    end

    for (genvar g = 0; g < OUT_SIZE; g++) begin : g_pack
        assign out_data[g*OUT_WIDTH +: OUT_WIDTH] = y_q[g];
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign wr_err    = wr_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_int_linear_tm.sv
// Bench for int_linear_tm: a RELU and a NONE instance share all inputs and are
// compared against a plain-arithmetic model of y = act(sat(round((W*x + b*2^13) / 2^13))).
module tb_int_linear_tm;
    localparam int IN  = 14;
    localparam int OUT = 12;
    localparam int AWD = 14;
    localparam int OW  = 14;
    localparam int NC  = IN*OUT + OUT;
    localparam int LAT = 60;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic              wr_en = 1'b0;
    logic [IN*AWD-1:0] in_data = '0;
    logic [7:0]        wr_addr = '0;
    logic [13:0]       wr_data = '0;

    logic              in_ready_r, out_valid_r, wr_err_r, busy_r;
    logic              in_ready_n, out_valid_n, wr_err_n, busy_n;
    logic [OUT*OW-1:0] out_data_r, out_data_n;

    int_linear_tm u_relu (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
        .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err_r), .busy(busy_r)
    );

    int_linear_tm #(.ACTIVATION("NONE")) u_none (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data),
        .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err_n), .busy(busy_n)
    );

    int checks = 0;
    int failures = 0;
    int coef_m [NC];
    int x_m [IN];
    int obs_r [OUT];
    int obs_n [OUT];

    function automatic int wrap14(int v);
        logic signed [13:0] t;
        t = v[13:0];
        return int'(t);
    endfunction

    function automatic int rnd(int lo, int hi);
        return lo + int'($urandom_range(0, hi - lo));
    endfunction

    function automatic int ref_y(int j, bit relu);
        longint r;
        longint q;
        r = 0;
        for (int i = 0; i < IN; i++) r += longint'(x_m[i]) * longint'(coef_m[j*IN + i]);
        r += longint'(coef_m[IN*OUT + j]) * 8192;
        q = (r + 4096) >>> 13;
        if (q > 8191)  q = 8191;
        if (q < -8192) q = -8192;
        if (relu && q < 0) q = 0;
        return int'(q);
    endfunction

    function automatic int out_r(int j);
        logic signed [OW-1:0] t;
        t = out_data_r[j*OW +: OW];
        return int'(t);
    endfunction

    function automatic int out_n(int j);
        logic signed [OW-1:0] t;
        t = out_data_n[j*OW +: OW];
        return int'(t);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NC; i++) coef_m[i] = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; wr_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_model();
        @(posedge clk); #1;
    endtask

    task automatic write_coef(input int addr, input int val, output bit err);
        wr_en = 1'b1; wr_addr = addr[7:0]; wr_data = val[13:0];
        @(posedge clk); #1;
        wr_en = 1'b0;
        err = wr_err_r | wr_err_n;
    endtask

    task automatic load_coef(input int addr, input int val, output bit err);
        write_coef(addr, val, err);
        coef_m[addr] = wrap14(val);
    endtask

    task automatic start_vector(output bit tmo);
        int cnt;
        for (int i = 0; i < IN; i++) in_data[i*AWD +: AWD] = x_m[i][13:0];
        in_valid = 1'b1;
        cnt = 0;
        while (!in_ready_r && cnt < 100) begin @(posedge clk); #1; cnt++; end
        tmo = !in_ready_r;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat_o, output bit tmo);
        lat_o = 0;
        while (!out_valid_r && lat_o < 200) begin @(posedge clk); #1; lat_o++; end
        tmo = !out_valid_r;
        for (int j = 0; j < OUT; j++) begin obs_r[j] = out_r(j); obs_n[j] = out_n(j); end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready_r !== 1'b0 || out_valid_r !== 1'b0 || busy_r !== 1'b0 || wr_err_r !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b wr_err=%b, required 0 0 0 0",
                     in_ready_r, out_valid_r, busy_r, wr_err_r);
        end
        checks++;
        if (out_data_r !== '0 || out_data_n !== '0) begin
            failures++;
            $display("FAIL reset_data: out_data relu=%h none=%h, required 0", out_data_r, out_data_n);
        end
        rst = 1'b0;
        clear_model();
        @(posedge clk); #1;
        checks++;
        if (in_ready_r !== 1'b1 || in_ready_n !== 1'b1 || busy_r !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b/%b busy=%b, required 1/1 0", in_ready_r, in_ready_n, busy_r);
        end
    endtask

    // 8192 does not fit a 14-bit signed weight; 8191 still maps x0=1000 to 1000.
    task automatic test_identity();
        bit err, tmo;
        int lat;
        load_coef(0, 8191, err);
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL identity_wr: wr_err=%b, required 0", err); end
        for (int i = 0; i < IN; i++) x_m[i] = rnd(-8192, 8191);
        x_m[0] = 1000;
        start_vector(tmo);
        checks++;
        if (busy_r !== 1'b1 || in_ready_r !== 1'b0) begin
            failures++;
            $display("FAIL identity_busy: busy=%b in_ready=%b, required 1 0", busy_r, in_ready_r);
        end
        wait_result(lat, tmo);
        checks++;
        if (tmo || lat != LAT) begin
            failures++;
            $display("FAIL identity_latency: cycles=%0d timeout=%b, required %0d", lat, tmo, LAT);
        end
        checks++;
        if (obs_n[0] != 1000 || obs_r[0] != 1000) begin
            failures++;
            $display("FAIL identity_out0: none=%0d relu=%0d, required 1000", obs_n[0], obs_r[0]);
        end
        for (int j = 0; j < OUT; j++) begin
            checks++;
            if (obs_r[j] != ref_y(j, 1'b1) || obs_n[j] != ref_y(j, 1'b0)) begin
                failures++;
                $display("FAIL identity_out%0d: relu=%0d none=%0d, required %0d %0d",
                         j, obs_r[j], obs_n[j], ref_y(j, 1'b1), ref_y(j, 1'b0));
            end
        end
        handshake();
        checks++;
        if (out_valid_r !== 1'b0 || in_ready_r !== 1'b1) begin
            failures++;
            $display("FAIL identity_handshake: out_valid=%b in_ready=%b, required 0 1", out_valid_r, in_ready_r);
        end
    endtask

    task automatic test_rounding();
        bit err, tmo;
        int lat;
        int xs [2];
        int want_n [2];
        xs[0] = 3;  want_n[0] = 2;
        xs[1] = -3; want_n[1] = -1;
        load_coef(0, 4096, err);
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < IN; i++) x_m[i] = 0;
            x_m[0] = xs[t];
            start_vector(tmo);
            wait_result(lat, tmo);
            checks++;
            if (tmo || obs_n[0] != want_n[t] || obs_r[0] != (want_n[t] < 0 ? 0 : want_n[t])) begin
                failures++;
                $display("FAIL rounding_x%0d: none=%0d relu=%0d timeout=%b, required %0d %0d",
                         xs[t], obs_n[0], obs_r[0], tmo, want_n[t], (want_n[t] < 0 ? 0 : want_n[t]));
            end
            handshake();
        end
    endtask

    task automatic test_saturation();
        bit err, tmo;
        int lat;
        int bs [2];
        int xs [2];
        int want_n [2];
        bs[0] = 8191;  xs[0] = 1000;  want_n[0] = 8191;
        bs[1] = -8192; xs[1] = -1000; want_n[1] = -8192;
        load_coef(0, 8191, err);
        for (int t = 0; t < 2; t++) begin
            load_coef(IN*OUT, bs[t], err);
            for (int i = 0; i < IN; i++) x_m[i] = 0;
            x_m[0] = xs[t];
            start_vector(tmo);
            wait_result(lat, tmo);
            checks++;
            if (tmo || obs_n[0] != want_n[t] || obs_n[0] != ref_y(0, 1'b0)
                || obs_r[0] != (want_n[t] < 0 ? 0 : want_n[t])) begin
                failures++;
                $display("FAIL saturation_%0d: none=%0d relu=%0d timeout=%b, required %0d",
                         t, obs_n[0], obs_r[0], tmo, want_n[t]);
            end
            handshake();
        end
    endtask

    task automatic test_relu();
        bit err, tmo;
        int lat;
        apply_reset();
        load_coef(IN*OUT + 3, -100, err);
        load_coef(IN*OUT + 4, 57, err);
        for (int i = 0; i < IN; i++) x_m[i] = rnd(-8192, 8191);
        start_vector(tmo);
        wait_result(lat, tmo);
        checks++;
        if (tmo || obs_r[3] != 0 || obs_n[3] != -100) begin
            failures++;
            $display("FAIL relu_out3: relu=%0d none=%0d timeout=%b, required 0 -100", obs_r[3], obs_n[3], tmo);
        end
        checks++;
        if (obs_r[4] != 57 || obs_n[4] != 57) begin
            failures++;
            $display("FAIL relu_out4: relu=%0d none=%0d, required 57 57", obs_r[4], obs_n[4]);
        end
        for (int j = 0; j < OUT; j++) begin
            checks++;
            if (obs_r[j] != ref_y(j, 1'b1) || obs_n[j] != ref_y(j, 1'b0)) begin
                failures++;
                $display("FAIL relu_out%0d: relu=%0d none=%0d, required %0d %0d",
                         j, obs_r[j], obs_n[j], ref_y(j, 1'b1), ref_y(j, 1'b0));
            end
        end
        handshake();
    endtask

    task automatic test_random();
        bit err, tmo;
        int lat;
        int wmax;
        int nerr;
        for (int round = 0; round < 3; round++) begin
            wmax = (round == 0) ? 256 : (round == 1) ? 8192 : 64;
            nerr = 0;
            for (int a = 0; a < NC; a++) begin
                load_coef(a, (a < IN*OUT) ? rnd(-wmax, wmax - 1) : rnd(-8192, 8191), err);
                if (err) nerr++;
            end
            checks++;
            if (nerr != 0) begin
                failures++;
                $display("FAIL random_wr%0d: rejected=%0d, required 0", round, nerr);
            end
            for (int v = 0; v < 2; v++) begin
                for (int i = 0; i < IN; i++) x_m[i] = rnd(-8192, 8191);
                start_vector(tmo);
                wait_result(lat, tmo);
                checks++;
                if (tmo || lat != LAT) begin
                    failures++;
                    $display("FAIL random_latency: cycles=%0d timeout=%b, required %0d", lat, tmo, LAT);
                end
                for (int j = 0; j < OUT; j++) begin
                    checks++;
                    if (obs_r[j] != ref_y(j, 1'b1) || obs_n[j] != ref_y(j, 1'b0)) begin
                        failures++;
                        $display("FAIL random_r%0d_v%0d_out%0d: relu=%0d none=%0d, required %0d %0d",
                                 round, v, j, obs_r[j], obs_n[j], ref_y(j, 1'b1), ref_y(j, 1'b0));
                    end
                end
                handshake();
                checks++;
                if (out_valid_r !== 1'b0 || in_ready_r !== 1'b1) begin
                    failures++;
                    $display("FAIL random_handshake: out_valid=%b in_ready=%b, required 0 1",
                             out_valid_r, in_ready_r);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit err, tmo;
        int lat;
        logic [OUT*OW-1:0] held_r, held_n;
        for (int i = 0; i < IN; i++) x_m[i] = rnd(-8192, 8191);
        x_m[0] = 4000;
        start_vector(tmo);
        wait_result(lat, tmo);
        held_r = out_data_r;
        held_n = out_data_n;
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin
                write_coef(0, coef_m[0] + 1000, err);
                checks++;
                if (err !== 1'b1) begin failures++; $display("FAIL bp_write_done: wr_err=%b, required 1", err); end
            end else begin
                @(posedge clk); #1;
            end
            if (c == 6) begin
                checks++;
                if (wr_err_r !== 1'b0) begin failures++; $display("FAIL bp_err_pulse: wr_err=%b, required 0", wr_err_r); end
            end
            checks++;
            if (out_valid_r !== 1'b1 || in_ready_r !== 1'b0 || out_data_r !== held_r || out_data_n !== held_n) begin
                failures++;
                $display("FAIL bp_hold_c%0d: out_valid=%b in_ready=%b data_stable=%b, required 1 0 1",
                         c, out_valid_r, in_ready_r, (out_data_r === held_r && out_data_n === held_n));
            end
        end
        handshake();
        checks++;
        if (out_valid_r !== 1'b0) begin failures++; $display("FAIL bp_release: out_valid=%b, required 0", out_valid_r); end
        write_coef(NC, 1234, err);
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL bp_addr180: wr_err=%b, required 1", err); end
        write_coef(255, 1234, err);
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL bp_addr255: wr_err=%b, required 1", err); end
        start_vector(tmo);
        wait_result(lat, tmo);
        for (int j = 0; j < OUT; j++) begin
            checks++;
            if (tmo || obs_r[j] != ref_y(j, 1'b1) || obs_n[j] != ref_y(j, 1'b0)) begin
                failures++;
                $display("FAIL bp_after_out%0d: relu=%0d none=%0d, required %0d %0d",
                         j, obs_r[j], obs_n[j], ref_y(j, 1'b1), ref_y(j, 1'b0));
            end
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        bit err, tmo;
        int lat;
        for (int i = 0; i < IN; i++) x_m[i] = rnd(-8192, 8191);
        start_vector(tmo);
        write_coef(5, 77, err);
        checks++;
        if (err !== 1'b1 || busy_r !== 1'b1) begin
            failures++;
            $display("FAIL mid_write_busy: wr_err=%b busy=%b, required 1 1", err, busy_r);
        end
        repeat (28) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid_r !== 1'b0 || busy_r !== 1'b0 || busy_n !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: out_valid=%b busy=%b/%b, required 0 0/0", out_valid_r, busy_r, busy_n);
        end
        rst = 1'b0;
        clear_model();
        @(posedge clk); #1;
        checks++;
        if (in_ready_r !== 1'b1) begin failures++; $display("FAIL mid_ready: in_ready=%b, required 1", in_ready_r); end
        for (int i = 0; i < IN; i++) x_m[i] = rnd(-8192, 8191);
        start_vector(tmo);
        wait_result(lat, tmo);
        for (int j = 0; j < OUT; j++) begin
            checks++;
            if (tmo || obs_r[j] != 0 || obs_n[j] != ref_y(j, 1'b0)) begin
                failures++;
                $display("FAIL mid_cleared_out%0d: relu=%0d none=%0d timeout=%b, required 0 0",
                         j, obs_r[j], obs_n[j], tmo);
            end
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_rounding();
        test_saturation();
        test_relu();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
